load_extend_unit: RTL and testbench
===================================

Name: load_extend_unit

Overview:
- Registered load-data formatter between the data memory read port (do0) and the register-file write-back mux.
- Selects a byte, halfword, word or (when DATA_W=64) doubleword lane from the memory read word using the low address bits.
- Sign- or zero-extends the selected lane to DATA_W bits.
- Uses a valid/ready handshake with a 2-entry output skid buffer, so memory-side timing is decoupled from write-back stalls.

Parameters:
- DATA_W, 32, memory word and output width; legal values 32 or 64.
- OFS_W, $clog2(DATA_W/8), width of the byte-offset input (2 for 32-bit, 3 for 64-bit).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- Entrada  input  DATA_W  raw memory read word (do0).
- Offset  input  OFS_W  byte address low bits.
- Tamano  input  2  lane size: 00 byte, 01 half, 10 word, 11 doubleword.
- Signo  input  1  1 = sign-extend, 0 = zero-extend.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- Salida  output  DATA_W  extended result.
- Error  output  1  beat flagged misaligned or illegal size (see Optional Feature).

Behaviour:
- Reset (asynchronous on rst_n low): out_valid=0, Salida=0, Error=0, skid buffer empty, in_ready=1 once rst_n is high.
- Transfer rules:
  - An input beat transfers when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
- Latency: 1 cycle. A beat accepted at edge N is presented at out_valid after edge N when the buffer is empty.
- Lane select: lane = Entrada >> (8*Offset), then masked to the size (8/16/32/64 bits).
- Extension: when Signo=1, bits above the lane take the lane MSB. When Signo=0, they are 0. Word with DATA_W=32 passes through unchanged regardless of Signo.
- Illegal size: Tamano=11 with DATA_W=32, or Tamano=10/11 beyond DATA_W. Treated as a word/full-width pass-through, with Error=1 for that beat.
- Skid buffer has two entries (main, skid) and states EMPTY, ONE, FULL:
  - EMPTY: in transfer -> ONE.
  - ONE:
    - in transfer and no out transfer -> FULL.
    - out transfer and no in transfer -> EMPTY.
    - both -> ONE, with the new beat replacing the head.
  - FULL:
    - out transfer -> ONE; the skid entry moves to the head.
    - in transfer impossible, since in_ready=0.
- in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
- Ordering: beats exit strictly in acceptance order; no beat is dropped or duplicated.
- While out_valid=1 && out_ready=0, Salida and Error stay stable.
- Offset wrap: the lane must lie inside the word. An offset whose lane crosses the top byte is handled per Optional Feature.
- Reset mid-operation: all buffered beats are discarded; out_valid drops asynchronously.

Optional Feature:
- Macro: LOAD_EXT_MISALIGN_CHK_EN.
- Defined:
  - Offset must be a multiple of the lane size in bytes. A violation sets Error=1 on that beat.
  - Salida for that beat is forced to 0.
  - The beat still flows through the handshake normally.
- Undefined:
  - No alignment check; Error reflects only illegal size.
  - A lane that crosses the top byte is filled from the available bytes, with missing high bytes read as 0 before extension.

Test Plan:
1. DATA_W=32, Entrada=0x12345680, Offset=0, Tamano=00, Signo=1 -> Salida=0xFFFFFF80 one cycle later, Error=0. Same beat with Signo=0 -> 0x00000080.
2. DATA_W=32, Entrada=0x8001ABCD, Offset=2, Tamano=01, Signo=1 -> Salida=0xFFFF8001. Same beat with Offset=1 and macro defined -> Error=1, Salida=0.
3. DATA_W=64, Entrada=0xF000000000000000, Offset=4, Tamano=10, Signo=1 -> Salida=0xFFFFFFFFF0000000. Same beat with Tamano=11, Offset=0 -> pass-through, Error=0.
4. Backpressure:
   - Stimulus: hold out_ready=0 and send 3 consecutive beats (A, B, C).
   - Required: in_ready falls after B is accepted. C waits.
   - Then raise out_ready: outputs appear in order A, B, C with no loss, and in_ready returns to 1.
5. Simultaneous accept/emit: in ONE state, drive in_valid=1 and out_ready=1 every cycle for 10 beats -> one result per cycle, state stays ONE, in_ready stays 1.
6. Reset mid-operation: assert rst_n=0 asynchronously while FULL -> out_valid=0 and Salida=0 immediately. After release, the first new beat emerges after 1 cycle.

Source files
------------

// File: rtl/load_extend_unit.sv
// Load-data formatter: lane select plus sign/zero extension, behind a 2-entry output skid buffer.
// Define LOAD_EXT_MISALIGN_CHK_EN to flag misaligned beats (Error=1, Salida=0).
module load_extend_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Entrada,
    input  logic [OFS_W-1:0]  Offset,
    input  logic [1:0]        Tamano,
    input  logic              Signo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Salida,
    output logic              Error
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e            state_q;
    logic              in_ready_q, out_valid_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              main_err_q, skid_err_q;

    logic              illegal;
    logic [1:0]        eff_sz;
    int unsigned       lane_bits;
    logic [DATA_W-1:0] shifted, mask, lane;
    logic              sign_bit;
    logic [DATA_W-1:0] fmt_data_d;
    logic              fmt_err_d;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
    logic [OFS_W-1:0]  align_mask;
`endif

    // Bytes shifted in above the word top read as zero, so a lane crossing the top byte zero-fills.
    always_comb begin
        illegal   = (32'd8 << Tamano) > DATA_W;
        eff_sz    = illegal ? 2'(OFS_W) : Tamano;
        lane_bits = 32'd8 << eff_sz;
        shifted   = Entrada >> {Offset, 3'b000};
        mask      = '1;
        if (lane_bits < DATA_W) begin
            mask = mask >> (DATA_W - lane_bits);
        end
        lane       = shifted & mask;
        sign_bit   = |(lane & ~(mask >> 1));
        fmt_data_d = lane;
        if (Signo && sign_bit) begin
            fmt_data_d = lane | ~mask;
        end
        fmt_err_d = illegal;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        align_mask = OFS_W'((32'd1 << eff_sz) - 32'd1);
        if ((Offset & align_mask) != '0) begin
            fmt_err_d  = 1'b1;
            fmt_data_d = '0;
        end
`endif
    end

    logic in_xfer, out_xfer;
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_data_q <= fmt_data_d;
                        main_err_q  <= fmt_err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_data_q <= fmt_data_d;
                        skid_err_q  <= fmt_err_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= FULL;
                    end else if (out_xfer && !in_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_data_q <= fmt_data_d;
                        main_err_q  <= fmt_err_d;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_data_q <= skid_data_q;
                        main_err_q  <= skid_err_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Salida    = main_data_q;
    assign Error     = main_err_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed checks of lane select, extension, skid-buffer handshake and reset for 32- and 64-bit builds.
module tb_load_extend_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, s32, e32;
    logic [31:0] d32, q32;
    logic [1:0]  o32, t32;

    logic        iv64, ir64, ov64, or64, s64, e64;
    logic [63:0] d64, q64;
    logic [2:0]  o64;
    logic [1:0]  t64;

    load_extend_unit #(.DATA_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .Entrada(d32), .Offset(o32), .Tamano(t32), .Signo(s32),
        .out_valid(ov32), .out_ready(or32), .Salida(q32), .Error(e32)
    );

    load_extend_unit #(.DATA_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .Entrada(d64), .Offset(o64), .Tamano(t64), .Signo(s64),
        .out_valid(ov64), .out_ready(or64), .Salida(q64), .Error(e64)
    );

    int total  = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic beat32(input string tag, input logic [31:0] d, input logic [1:0] o,
                          input logic [1:0] t, input logic s,
                          input logic [31:0] exp_q, input logic exp_e);
        @(negedge clk);
        iv32 = 1'b1; d32 = d; o32 = o; t32 = t; s32 = s;
        @(posedge clk); #1;
        iv32 = 1'b0;
        chk({tag, "_valid"}, 64'(ov32), 64'd1);
        chk({tag, "_data"}, 64'(q32), 64'(exp_q));
        chk({tag, "_err"}, 64'(e32), 64'(exp_e));
    endtask

    task automatic beat64(input string tag, input logic [63:0] d, input logic [2:0] o,
                          input logic [1:0] t, input logic s,
                          input logic [63:0] exp_q, input logic exp_e);
        @(negedge clk);
        iv64 = 1'b1; d64 = d; o64 = o; t64 = t; s64 = s;
        @(posedge clk); #1;
        iv64 = 1'b0;
        chk({tag, "_valid"}, 64'(ov64), 64'd1);
        chk({tag, "_data"}, q64, exp_q);
        chk({tag, "_err"}, 64'(e64), 64'(exp_e));
    endtask

    initial begin
        rst_n = 1'b0;
        iv32 = 0; or32 = 1; d32 = '0; o32 = '0; t32 = '0; s32 = 0;
        iv64 = 0; or64 = 1; d64 = '0; o64 = '0; t64 = '0; s64 = 0;
        #12;
        chk("rst_valid", 64'(ov32), 64'd0);
        chk("rst_data", 64'(q32), 64'd0);
        chk("rst_err", 64'(e32), 64'd0);
        chk("rst_ready", 64'(ir32), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane select / extension, 32-bit
        beat32("b0_sx", 32'h12345680, 2'd0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
        beat32("b0_zx", 32'h12345680, 2'd0, 2'b00, 1'b0, 32'h00000080, 1'b0);
        beat32("h2_sx", 32'h8001ABCD, 2'd2, 2'b01, 1'b1, 32'hFFFF8001, 1'b0);
        beat32("b3_sx", 32'h8001ABCD, 2'd3, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
        beat32("w_sx", 32'h8001ABCD, 2'd0, 2'b10, 1'b1, 32'h8001ABCD, 1'b0);
        beat32("ill32", 32'h8001ABCD, 2'd0, 2'b11, 1'b1, 32'h8001ABCD, 1'b1);
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        beat32("h1_mis", 32'h8001ABCD, 2'd1, 2'b01, 1'b1, 32'h00000000, 1'b1);
        beat32("h3_mis", 32'h8001ABCD, 2'd3, 2'b01, 1'b1, 32'h00000000, 1'b1);
`else
        beat32("h1_mis", 32'h8001ABCD, 2'd1, 2'b01, 1'b1, 32'h000001AB, 1'b0);
        beat32("h3_wrap", 32'h8001ABCD, 2'd3, 2'b01, 1'b1, 32'h00000080, 1'b0);
`endif

        // 64-bit build
        beat64("w4_sx", 64'hF000000000000000, 3'd4, 2'b10, 1'b1, 64'hFFFFFFFFF0000000, 1'b0);
        beat64("w4_zx", 64'hF000000000000000, 3'd4, 2'b10, 1'b0, 64'h00000000F0000000, 1'b0);
        beat64("d0", 64'hF000000000000000, 3'd0, 2'b11, 1'b1, 64'hF000000000000000, 1'b0);
        beat64("h6_sx", 64'h8123000000000000, 3'd6, 2'b01, 1'b1, 64'hFFFFFFFFFFFF8123, 1'b0);

        // Drain to EMPTY
        @(negedge clk);
        @(posedge clk); #1;
        chk("drain_valid", 64'(ov32), 64'd0);

        // Backpressure: A, B, C with out_ready low
        @(negedge clk);
        or32 = 0; iv32 = 1; d32 = 32'hAAAA0001; o32 = 0; t32 = 2'b10; s32 = 0;
        @(posedge clk); #1;
        chk("bp_A_valid", 64'(ov32), 64'd1);
        chk("bp_A_ready", 64'(ir32), 64'd1);
        @(negedge clk);
        d32 = 32'hBBBB0002;
        @(posedge clk); #1;
        chk("bp_B_ready", 64'(ir32), 64'd0);
        chk("bp_B_head", 64'(q32), 64'hAAAA0001);
        @(negedge clk);
        d32 = 32'hCCCC0003;
        @(posedge clk); #1;
        chk("bp_C_wait", 64'(ir32), 64'd0);
        chk("bp_stable", 64'(q32), 64'hAAAA0001);
        @(negedge clk);
        or32 = 1;
        chk("bp_out_A", 64'(q32), 64'hAAAA0001);
        @(posedge clk); #1;
        chk("bp_out_B", 64'(q32), 64'hBBBB0002);
        chk("bp_ready_back", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        chk("bp_out_C", 64'(q32), 64'hCCCC0003);
        @(negedge clk);
        iv32 = 0;
        @(posedge clk); #1;
        chk("bp_empty", 64'(ov32), 64'd0);
        chk("bp_ready_end", 64'(ir32), 64'd1);

        // Streaming: one result per cycle, in_ready held high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv32 = 1; or32 = 1; d32 = 32'h00001000 + 32'(i); t32 = 2'b10;
            @(posedge clk); #1;
            chk("st_data", 64'(q32), 64'h1000 + 64'(i));
            chk("st_ready", 64'(ir32), 64'd1);
            chk("st_valid", 64'(ov32), 64'd1);
        end
        @(negedge clk);
        iv32 = 0;
        @(posedge clk); #1;
        chk("st_empty", 64'(ov32), 64'd0);

        // Reset while FULL
        @(negedge clk);
        or32 = 0; iv32 = 1; d32 = 32'h9999_0001; t32 = 2'b11;
        @(posedge clk); #1;
        chk("rf_err_pre", 64'(e32), 64'd1);
        @(negedge clk);
        d32 = 32'h9999_0002; t32 = 2'b10;
        @(posedge clk); #1;
        chk("rf_full", 64'(ir32), 64'd0);
        @(negedge clk);
        iv32 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rf_valid", 64'(ov32), 64'd0);
        chk("rf_data", 64'(q32), 64'd0);
        chk("rf_err", 64'(e32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; or32 = 1;
        beat32("rf_new", 32'h0000_00FF, 2'd0, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
